// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with byte-enabled stores; DMEM_ALIGN_CHECK_EN enables misaligned-access flagging
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic we_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0] be_q;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic accept, fire, err;
  logic unused_addr;
  assign idx = addr_q[AW+1:2];
  assign fire = state == BUSY && cnt == 4'd1;
  assign unused_addr = ^{req_addr[31:AW+2], addr_q[1:0]};
`ifdef DMEM_ALIGN_CHECK_EN
  logic be_byte, be_half;
  assign be_byte = be_q inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
  assign be_half = be_q inside {4'b0011, 4'b1100};
  assign err = !we_q ? addr_q[1:0] != 2'b00 :
               be_byte ? 1'b0 :
               be_half ? addr_q[0] :
               be_q == 4'b1111 ? addr_q[1:0] != 2'b00 : 1'b1;
`else
  assign err = 1'b0;
`endif
  always_comb begin
    req_ready = state != BUSY;
    rsp_valid = state == RESP;
    accept    = req_ready && req_valid;
    state_nx  = accept ? BUSY : fire ? RESP : state == BUSY ? BUSY : IDLE;
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt     <= 4'(LATENCY);
      end else if (state == BUSY)
        cnt <= cnt - 4'd1;
      if (fire) begin
        rsp_rdata <= (we_q || err) ? 32'd0 : mem[idx];
        rsp_err   <= err;
      end
    end
  // Array has no reset so contents survive clr_n; fire is already low once reset asserts.
  always_ff @(posedge clk)
    if (clr_n && fire && we_q && !err)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
endmodule
